// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, loader state encoding and length check helper
package proc_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int LEN_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   // A load is legal when it carries at least one word and fits in 2**addr_w words.
   function automatic logic len_in_range(input logic [LEN_W-1:0] n, input int addr_w);
      logic [LEN_W:0] cap;
      cap = (LEN_W+1)'(1) << addr_w;
      return (n != '0) && ({1'b0, n} <= cap);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction-memory write port out
interface imem_loader_if
   import proc_pkg::*;
#(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WORD_W-1:0] wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, we, waddr, wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, we, waddr, wdata
   );
endinterface

// File: rtl/imem_word_asm.sv
// rtl/imem_word_asm.sv - packs little-endian bytes into 32-bit words, one registered pulse per word
module imem_word_asm
   import proc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [1:0]        lane,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   // Lower three bytes of the word under construction; byte 0 ends up in the low lane.
   logic [WORD_W-BYTE_W-1:0] shreg;

   // Lane counter, shift register and registered word/strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane       <= 2'd0;
         shreg      <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            lane  <= 2'd0;
            shreg <= '0;
         end else if (byte_valid) begin
            lane  <= lane + 2'd1;
            shreg <= {byte_data, shreg[WORD_W-BYTE_W-1:BYTE_W]};
            if (lane == 2'd3) begin
               word       <= {byte_data, shreg};
               word_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream instruction-memory loader (LOADER_CHECKSUM_EN adds trailing XOR byte check)
module imem_loader
   import proc_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   imem_loader_if.slave bus,
   output logic         cpu_reset,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

   loader_state_t     state, state_n;
   logic              hs;
   logic              start_ok;
   logic              data_byte;
   logic              last_byte;
   logic [BYTE_W-1:0] len_lo;
   logic [LEN_W:0]    rem;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        lane;
   logic              word_valid;
   logic [WORD_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum;
`endif

   assign bus.in_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                         (state == ST_DATA)   || (state == ST_CHK);
   assign hs        = bus.in_valid && bus.in_ready;
   assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
   assign data_byte = hs && (state == ST_DATA);
   assign last_byte = data_byte && (lane == 2'd3) && (rem == REM_ONE);

   assign bus.we    = word_valid;
   assign bus.wdata = word;
   assign bus.waddr = addr;

   imem_word_asm u_word_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_ok),
      .byte_valid (data_byte),
      .byte_data  (bus.in_data),
      .lane       (lane),
      .word_valid (word_valid),
      .word       (word)
   );

   // Next-state decode.
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE, ST_DONE, ST_ERR: if (start) state_n = ST_LEN_LO;
         ST_LEN_LO: if (hs) state_n = ST_LEN_HI;
         ST_LEN_HI: if (hs) state_n = len_in_range({bus.in_data, len_lo}, ADDR_W) ? ST_DATA : ST_ERR;
`ifdef LOADER_CHECKSUM_EN
         ST_DATA:   if (last_byte) state_n = ST_CHK;
         ST_CHK:    if (hs) state_n = (bus.in_data == csum) ? ST_DONE : ST_ERR;
`else
         ST_DATA:   if (last_byte) state_n = ST_DONE;
`endif
         default:   state_n = ST_IDLE;
      endcase
   end

   // State register; status flags are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         cpu_reset <= (state_n != ST_DONE);
         busy      <= (state_n == ST_LEN_LO) || (state_n == ST_LEN_HI) ||
                      (state_n == ST_DATA)   || (state_n == ST_CHK);
         done      <= (state_n == ST_DONE);
         err       <= (state_n == ST_ERR);
      end
   end

   // Length capture, remaining-word count and write address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_lo <= '0;
         rem    <= '0;
         addr   <= '0;
      end else begin
         if (hs && (state == ST_LEN_LO)) len_lo <= bus.in_data;
         if (hs && (state == ST_LEN_HI)) begin
            rem <= {1'b0, bus.in_data, len_lo};
         end else if (data_byte && (lane == 2'd3)) begin
            rem <= rem - REM_ONE;
         end
         if (start_ok) begin
            addr <= '0;
         end else if (word_valid) begin
            addr <= addr + ADDR_W'(1);
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running XOR of every data byte, compared against the trailing check byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum <= '0;
      end else if (start_ok) begin
         csum <= '0;
      end else if (data_byte) begin
         csum <= csum ^ bus.in_data;
      end
   end
`endif

endmodule
